// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control unit:
// opcodes, funct codes, FSM state encoding, ALU codes and the control word.
package mips_ctrl_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned ULA_BASE_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ULA_BASE_W-1:0] ULA_ADD = 3'b010;
  localparam logic [ULA_BASE_W-1:0] ULA_SUB = 3'b110;
  localparam logic [ULA_BASE_W-1:0] ULA_AND = 3'b000;
  localparam logic [ULA_BASE_W-1:0] ULA_OR  = 3'b001;
  localparam logic [ULA_BASE_W-1:0] ULA_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BNE      = 4'd12
  } estado_t;

  typedef struct packed {
    logic                  pc_write;
    logic                  branch;
    logic                  branch_ne;
    logic                  iord;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic [ULA_BASE_W-1:0] ula;
    logic                  illegal;
  } ctrl_t;

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control-unit <-> datapath bundle: instruction fields and flag in, control word out.
interface unidade_controle_multiciclo_if #(
  parameter int unsigned ULA_W = 3
);
  logic [mips_ctrl_pkg::OP_W-1:0]    OP;
  logic [mips_ctrl_pkg::FUNCT_W-1:0] Funct;
  logic                              Zero;
  logic                              PCEn;
  logic                              IorD;
  logic                              MemWrite;
  logic                              IRWrite;
  logic                              RegWrite;
  logic                              RegDst;
  logic                              MemtoReg;
  logic                              ALUSrcA;
  logic [1:0]                        ALUSrcB;
  logic [1:0]                        PCSrc;
  logic [ULA_W-1:0]                  ULA_Control;
  logic                              Illegal;
  logic [mips_ctrl_pkg::STATE_W-1:0] Estado;

  modport master (
    input  OP, Funct, Zero,
    output PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSrc, ULA_Control, Illegal, Estado
  );

  modport slave (
    output OP, Funct, Zero,
    input  PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSrc, ULA_Control, Illegal, Estado
  );
endinterface

// File: rtl/decodificador_ula.sv
// R-type funct to ALU operation decoder; valid is low for unknown funct codes.
module decodificador_ula
  import mips_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ULA_BASE_W-1:0] ula_op,
  output logic                  valid
);

  always_comb begin
    ula_op = ULA_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  ula_op = ULA_ADD;
      FN_SUB:  ula_op = ULA_SUB;
      FN_AND:  ula_op = ULA_AND;
      FN_OR:   ula_op = ULA_OR;
      FN_SLT:  ula_op = ULA_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback; only PCEn depends combinationally on Zero.
module unidade_controle_multiciclo
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ULA_W  = 3,
  parameter bit          EN_BNE = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  unidade_controle_multiciclo_if.master bus
);

  estado_t                state_q;
  estado_t                state_d;
  ctrl_t                  ctrl;
  logic [ULA_BASE_W-1:0]  funct_ula;
  logic                   funct_ok;

  decodificador_ula u_dec (
    .funct  (bus.Funct),
    .ula_op (funct_ula),
    .valid  (funct_ok)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore control word
  always_comb begin
    state_d = S_FETCH;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.ula       = ULA_ADD;
        state_d        = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.ula       = ULA_ADD;
        case (bus.OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) state_d = S_EXECUTE;
            else          ctrl.illegal = 1'b1;
          end
          OP_BEQ: state_d = S_BEQ;
          OP_BNE: begin
            if (EN_BNE) state_d = S_BNE;
            else        ctrl.illegal = 1'b1;
          end
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ula       = ULA_ADD;
        state_d        = (bus.OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.iord = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.ula       = funct_ula;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.ula       = ULA_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ula       = ULA_ADD;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_BNE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.ula       = ULA_SUB;
        ctrl.branch_ne = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Held reset forces every enable and select low; Estado still shows the register
  always_comb begin
    bus.PCEn        = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSrc       = 2'b00;
    bus.ULA_Control = '0;
    bus.Illegal     = 1'b0;
    bus.Estado      = STATE_W'(state_q);
    if (rst_n) begin
      bus.PCEn        = ctrl.pc_write | (ctrl.branch & bus.Zero) | (ctrl.branch_ne & ~bus.Zero);
      bus.IorD        = ctrl.iord;
      bus.MemWrite    = ctrl.mem_write;
      bus.IRWrite     = ctrl.ir_write;
      bus.RegWrite    = ctrl.reg_write;
      bus.RegDst      = ctrl.reg_dst;
      bus.MemtoReg    = ctrl.mem_to_reg;
      bus.ALUSrcA     = ctrl.alu_src_a;
      bus.ALUSrcB     = ctrl.alu_src_b;
      bus.PCSrc       = ctrl.pc_src;
      bus.ULA_Control = ULA_W'(ctrl.ula);
      bus.Illegal     = ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench: per-instruction state/output sequences compared against
// a table-driven reference built from instruction class and CPI.
module tb_unidade_controle_multiciclo;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] ula;
    logic       illegal;
    logic [3:0] estado;
  } obs_t;

  localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_R = 3, K_BEQ = 4,
                 K_BNE = 5, K_ADDI = 6, K_J = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  unidade_controle_multiciclo_if #(.ULA_W(4)) bus1 ();
  unidade_controle_multiciclo_if #(.ULA_W(3)) bus0 ();

  unidade_controle_multiciclo #(.ULA_W(4), .EN_BNE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  unidade_controle_multiciclo #(.ULA_W(3), .EN_BNE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  // ---------------- reference model ----------------
  function automatic bit funct_known(logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [3:0] funct_code(logic [5:0] f);
    case (f)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic int klass(logic [5:0] op, logic [5:0] f, bit en);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return funct_known(f) ? K_R : K_ILL;
      6'b000100: return K_BEQ;
      6'b000101: return en ? K_BNE : K_ILL;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int cpi(int c);
    case (c)
      K_LW:                return 5;
      K_SW, K_R, K_ADDI:   return 4;
      K_BEQ, K_BNE, K_J:   return 3;
      default:             return 2;
    endcase
  endfunction

  function automatic int state_at(int c, int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    case (c)
      K_LW:    return k + 0;
      K_SW:    return (k == 2) ? 2 : 5;
      K_R:     return (k == 2) ? 6 : 7;
      K_BEQ:   return 8;
      K_BNE:   return 12;
      K_ADDI:  return (k == 2) ? 9 : 10;
      K_J:     return 11;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t exp_out(int s, logic [5:0] f, logic z, bit ill);
    obs_t o = '0;
    o.estado = 4'(s);
    case (s)
      0:  begin o.irwrite = 1; o.pcen = 1; o.alusrcb = 2'b01; o.ula = 4'b0010; end
      1:  begin o.alusrcb = 2'b11; o.ula = 4'b0010; o.illegal = ill; end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.ula = 4'b0010; end
      3:  o.iord = 1;
      4:  begin o.regwrite = 1; o.memtoreg = 1; end
      5:  begin o.iord = 1; o.memwrite = 1; end
      6:  begin o.alusrca = 1; o.ula = funct_code(f); end
      7:  begin o.regwrite = 1; o.regdst = 1; end
      8:  begin o.alusrca = 1; o.ula = 4'b0110; o.pcsrc = 2'b01; o.pcen = z; end
      9:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.ula = 4'b0010; end
      10: o.regwrite = 1;
      11: begin o.pcen = 1; o.pcsrc = 2'b10; end
      12: begin o.alusrca = 1; o.ula = 4'b0110; o.pcsrc = 2'b01; o.pcen = ~z; end
      default: ;
    endcase
    return o;
  endfunction

  // ---------------- observation ----------------
  function automatic obs_t get_obs1();
    obs_t o;
    o.pcen = bus1.PCEn;     o.iord = bus1.IorD;       o.memwrite = bus1.MemWrite;
    o.irwrite = bus1.IRWrite; o.regwrite = bus1.RegWrite; o.regdst = bus1.RegDst;
    o.memtoreg = bus1.MemtoReg; o.alusrca = bus1.ALUSrcA; o.alusrcb = bus1.ALUSrcB;
    o.pcsrc = bus1.PCSrc;   o.ula = bus1.ULA_Control; o.illegal = bus1.Illegal;
    o.estado = bus1.Estado;
    return o;
  endfunction

  function automatic obs_t get_obs0();
    obs_t o;
    o.pcen = bus0.PCEn;     o.iord = bus0.IorD;       o.memwrite = bus0.MemWrite;
    o.irwrite = bus0.IRWrite; o.regwrite = bus0.RegWrite; o.regdst = bus0.RegDst;
    o.memtoreg = bus0.MemtoReg; o.alusrca = bus0.ALUSrcA; o.alusrcb = bus0.ALUSrcB;
    o.pcsrc = bus0.PCSrc;   o.ula = 4'(bus0.ULA_Control); o.illegal = bus0.Illegal;
    o.estado = bus0.Estado;
    return o;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] f, input logic z);
    bus1.OP = op; bus1.Funct = f; bus1.Zero = z;
    bus0.OP = op; bus0.Funct = f; bus0.Zero = z;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    obs_t o1, o0;
    rst_n = 1'b0;
    drive(6'h3f, 6'h00, 1'b1);
    @(posedge clk); #2;
    o1 = get_obs1(); o0 = get_obs0();
    checks++;
    if (o1 !== obs_t'(0)) begin
      errors++; $display("FAIL reset_dut1: got %h expected %h", o1, obs_t'(0));
    end
    checks++;
    if (o0 !== obs_t'(0)) begin
      errors++; $display("FAIL reset_dut0: got %h expected %h", o0, obs_t'(0));
    end
    rst_n = 1'b1;
  endtask

  // zmode: 0/1 forces Zero, 2 randomizes Zero every cycle
  task automatic run_check(input string name, input logic [5:0] op, input logic [5:0] f,
                           input int zmode, input int stop);
    int   c, n;
    logic z;
    obs_t o, e;
    c = klass(op, f, 1'b1);
    n = cpi(c);
    if (stop < n) n = stop;
    for (int k = 0; k < n; k++) begin
      z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      drive(op, f, z);
      #1;
      o = get_obs1();
      e = exp_out(state_at(c, k), f, z, c == K_ILL);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s op=%b fn=%b cyc%0d: got %h expected %h", name, op, f, k, o, e);
      end
      @(posedge clk); #2;
    end
  endtask

  // Runs one instruction on both the bne-enabled and bne-disabled units, then resyncs
  task automatic run_both(input string name, input logic [5:0] op, input logic [5:0] f);
    int   c1, c0, n1, n0, n;
    logic z;
    obs_t o, e;
    c1 = klass(op, f, 1'b1); n1 = cpi(c1);
    c0 = klass(op, f, 1'b0); n0 = cpi(c0);
    n  = (n1 > n0) ? n1 : n0;
    for (int k = 0; k < n; k++) begin
      z = 1'($urandom);
      drive(op, f, z);
      #1;
      if (k < n1) begin
        o = get_obs1(); e = exp_out(state_at(c1, k), f, z, c1 == K_ILL);
        checks++;
        if (o !== e) begin
          errors++; $display("FAIL %s_en1 cyc%0d: got %h expected %h", name, k, o, e);
        end
      end
      if (k < n0) begin
        o = get_obs0(); e = exp_out(state_at(c0, k), f, z, c0 == K_ILL);
        checks++;
        if (o !== e) begin
          errors++; $display("FAIL %s_en0 cyc%0d: got %h expected %h", name, k, o, e);
        end
      end
      @(posedge clk); #2;
    end
    test_reset();
  endtask

  task automatic test_lw();
    run_check("lw", OP_LW, 6'h15, 2, 99);
    run_check("sw", OP_SW, 6'h2a, 2, 99);
    run_check("addi", OP_ADDI, 6'h00, 2, 99);
  endtask

  task automatic test_rtype();
    run_check("r_sub", OP_RTYPE, FN_SUB, 2, 99);
    run_check("r_and", OP_RTYPE, FN_AND, 2, 99);
    run_check("r_or",  OP_RTYPE, FN_OR,  2, 99);
    run_check("r_slt", OP_RTYPE, FN_SLT, 2, 99);
    run_check("r_add", OP_RTYPE, FN_ADD, 2, 99);
  endtask

  task automatic test_branch();
    run_check("beq_z1", OP_BEQ, 6'h00, 1, 99);
    run_check("beq_z0", OP_BEQ, 6'h00, 0, 99);
    run_check("bne_z1", OP_BNE, 6'h00, 1, 99);
    run_check("bne_z0", OP_BNE, 6'h00, 0, 99);
    run_check("jump",   OP_J,   6'h00, 2, 99);
  endtask

  task automatic test_illegal();
    run_both("ill_op",    6'b111111, 6'b100000);
    run_both("ill_funct", OP_RTYPE,  6'b000000);
    run_both("bne_gate",  OP_BNE,    6'b000000);
  endtask

  task automatic test_mid_reset();
    obs_t o, e;
    run_check("lw_pre", OP_LW, 6'h00, 2, 4);
    rst_n = 1'b0;
    #1;
    o = get_obs1(); e = '0; e.estado = 4'd4;
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL midreset_hold: got %h expected %h", o, e);
    end
    @(posedge clk); #2;
    o = get_obs1(); e = '0;
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL midreset_state: got %h expected %h", o, e);
    end
    rst_n = 1'b1;
    run_check("after_reset", OP_ADDI, 6'h00, 2, 99);
  endtask

  task automatic test_random();
    logic [5:0] op, f;
    logic [5:0] ops [8];
    logic [5:0] fns [5];
    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
    ops[4] = OP_BNE;   ops[5] = OP_ADDI; ops[6] = OP_J; ops[7] = OP_RTYPE;
    fns[0] = FN_ADD; fns[1] = FN_SUB; fns[2] = FN_AND; fns[3] = FN_OR; fns[4] = FN_SLT;
    for (int i = 0; i < 80; i++) begin
      int oi, fi;
      oi = $urandom_range(0, 8);
      fi = $urandom_range(0, 5);
      op = (oi == 8) ? 6'($urandom) : ops[oi];
      f  = (fi == 5) ? 6'($urandom) : fns[fi];
      run_check("random", op, f, 2, 99);
    end
  endtask

  initial begin
    drive(6'h00, 6'h00, 1'b0);
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
